// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Program-memory responder for the PM fetch interface (memory side of
// instruction fetch). One fetch may be accepted per cycle. The response comes
// back exactly LATENCY cycles later, and responses stay in order. A byte-enabled
// write port preloads or patches the word array. A write in the same cycle as a
// fetch wins, and the fetch is held off.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous reset, active-high (clears response pipeline)
//   pm_rd_i          fetch request valid
//   pm_addr_i        fetch byte address
//   pm_ready_o       fetch accepted this cycle when high together with pm_rd_i
//   pm_instr_valid_o one-cycle response strobe
//   pm_instr_o       response instruction word (0 when not valid)
//   pm_err_o         response error, misaligned or out of range (0 when not valid)
//   wr_en_i          array write request
//   wr_addr_i        write byte address (word-aligned)
//   wr_data_i        write data
//   wr_be_i          write byte enables
// -----------------------------------------------------------------------------
module instr_mem #(
    parameter int               XLEN        = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               LATENCY     = 1,
    parameter logic [XLEN-1:0]  BASE_ADDR   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pm_rd_i,
    input  logic [XLEN-1:0]     pm_addr_i,
    output logic                pm_ready_o,
    output logic                pm_instr_valid_o,
    output logic [XLEN-1:0]     pm_instr_o,
    output logic                pm_err_o,
    input  logic                wr_en_i,
    input  logic [XLEN-1:0]     wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic [XLEN/8-1:0]   wr_be_i
);

    localparam int              BW      = $clog2(XLEN/8);
    localparam int              AW      = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] DEPTH_X = XLEN'(DEPTH_WORDS);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    logic [XLEN-1:0] w_rd_off;
    logic [XLEN-1:0] w_rd_widx;
    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_err;
    logic            w_accept;

    logic [XLEN-1:0] w_wr_off;
    logic [XLEN-1:0] w_wr_widx;
    logic [AW-1:0]   w_wr_idx;
    logic            w_wr_ok;

    logic            r_vld  [LATENCY];
    logic            r_err  [LATENCY];
    logic [XLEN-1:0] r_data [LATENCY];

    // The full-width word index is range-checked. This keeps an address near the
    // top of the address space from wrapping into the array.
    assign w_rd_off  = pm_addr_i - BASE_ADDR;
    assign w_rd_widx = w_rd_off >> BW;
    assign w_rd_idx  = w_rd_widx[AW-1:0];
    assign w_rd_err  = (pm_addr_i < BASE_ADDR) | (w_rd_widx >= DEPTH_X)
                     | (pm_addr_i[BW-1:0] != '0);

    assign w_wr_off  = wr_addr_i - BASE_ADDR;
    assign w_wr_widx = w_wr_off >> BW;
    assign w_wr_idx  = w_wr_widx[AW-1:0];
    assign w_wr_ok   = (wr_addr_i >= BASE_ADDR) & (w_wr_widx < DEPTH_X)
                     & (wr_addr_i[BW-1:0] == '0);

    assign pm_ready_o = ~wr_en_i;
    assign w_accept   = pm_rd_i & ~wr_en_i;

    // The array has no reset. Its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && w_wr_ok) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (wr_be_i[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 reads the array at the accept edge. Later stages only delay the
    // captured word. Data and err are zeroed on empty slots, so the outputs
    // need no extra gating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_err[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept & w_rd_err;
            if (!w_accept) begin
                r_data[0] <= '0;
            end else if (w_rd_err) begin
                r_data[0] <= NOP;
            end else begin
                r_data[0] <= r_mem[w_rd_idx];
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_err[i]  <= r_err[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign pm_instr_valid_o = r_vld[LATENCY-1];
    assign pm_err_o         = r_err[LATENCY-1];
    assign pm_instr_o       = r_data[LATENCY-1];

endmodule

// File: tb/tb_instr_mem.sv
module tb_instr_mem;

    localparam int DEPTH = 64;
    localparam int NI    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pm_rd;
    logic [31:0] pm_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic        rdy [NI];
    logic        vld [NI];
    logic        err [NI];
    logic [31:0] ins [NI];

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY 1, base 0. Instance 1: LATENCY 3, base 0x1000. Instance 2: LATENCY 2, base 0x1000.
    instr_mem #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk_i(clk), .rst_i(rst), .pm_rd_i(pm_rd), .pm_addr_i(pm_addr),
        .pm_ready_o(rdy[0]), .pm_instr_valid_o(vld[0]), .pm_instr_o(ins[0]), .pm_err_o(err[0]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be));
    instr_mem #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(32'h1000)) u_l3 (
        .clk_i(clk), .rst_i(rst), .pm_rd_i(pm_rd), .pm_addr_i(pm_addr),
        .pm_ready_o(rdy[1]), .pm_instr_valid_o(vld[1]), .pm_instr_o(ins[1]), .pm_err_o(err[1]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be));
    instr_mem #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(32'h1000)) u_l2 (
        .clk_i(clk), .rst_i(rst), .pm_rd_i(pm_rd), .pm_addr_i(pm_addr),
        .pm_ready_o(rdy[2]), .pm_instr_valid_o(vld[2]), .pm_instr_o(ins[2]), .pm_err_o(err[2]),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be));

    function automatic int lat_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] base_of(int k);
        return (k == 0) ? 32'h0 : 32'h1000;
    endfunction

    function automatic logic in_map(int k, logic [31:0] a);
        logic [31:0] b;
        b = base_of(k);
        if (a < b) return 1'b0;
        if (a[1:0] != 2'b00) return 1'b0;
        return ((a - b) / 4) < DEPTH;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference model: a word array per instance, plus a response ring keyed by
    // the edge number when each response becomes visible.
    logic [31:0] mem_m [NI][DEPTH];
    logic        m_v   [NI][8];
    logic        m_e   [NI][8];
    logic [31:0] m_d   [NI][8];
    int unsigned edge_cnt = 0;

    initial begin
        for (int k = 0; k < NI; k++)
            for (int s = 0; s < 8; s++) m_v[k][s] = 1'b0;
    end

    always @(posedge clk) begin
        int          s;
        int unsigned wi;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                for (int j = 0; j < 8; j++) m_v[k][j] = 1'b0;
            end else if (pm_rd && !wr_en) begin
                s = int'((edge_cnt + lat_of(k) - 1) % 8);
                m_v[k][s] = 1'b1;
                if (in_map(k, pm_addr)) begin
                    m_e[k][s] = 1'b0;
                    m_d[k][s] = mem_m[k][(pm_addr - base_of(k)) / 4];
                end else begin
                    m_e[k][s] = 1'b1;
                    m_d[k][s] = 32'h0000_0013;
                end
            end
            if (wr_en && in_map(k, wr_addr)) begin
                wi = (wr_addr - base_of(k)) / 4;
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) mem_m[k][wi][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        edge_cnt++;
    end

    always @(negedge clk) begin
        int s;
        if (chk_en) begin
            s = int'((edge_cnt - 1) % 8);
            for (int k = 0; k < NI; k++) begin
                chk("ready", k, 32'(rdy[k]), 32'(!wr_en));
                if (m_v[k][s]) begin
                    chk("valid", k, 32'(vld[k]), 32'd1);
                    chk("err",   k, 32'(err[k]), 32'(m_e[k][s]));
                    chk("instr", k, ins[k], m_d[k][s]);
                end else begin
                    chk("idle_valid", k, 32'(vld[k]), 32'd0);
                    chk("idle_err",   k, 32'(err[k]), 32'd0);
                    chk("idle_instr", k, ins[k], 32'd0);
                end
                m_v[k][s] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0; wr_be = 4'h0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: return 32'h1000 + 32'(4 * $urandom_range(0, 70));
            4, 5, 6:    return 32'(4 * $urandom_range(0, 70));
            7:          return $urandom;
            8:          return 32'h1000 + 32'($urandom_range(0, 300));
            default:    return 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        rst = 1'b1; pm_rd = 1'b0; pm_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", k, 32'(vld[k]), 32'd0);
            chk("rst_instr", k, ins[k], 32'd0);
            chk("rst_err",   k, 32'(err[k]), 32'd0);
        end
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) begin
            d = (w == 0) ? 32'h0050_0093 : (w == 1) ? 32'h0010_0113 : $urandom;
            write_word(32'(4 * w), d, 4'hF);
            write_word(32'h1000 + 32'(4 * w), d, 4'hF);
        end

        // Streaming fetch on the LATENCY=1 instance
        pm_rd = 1'b1; pm_addr = 32'h0;
        tick();
        chk("t1_valid0", 0, 32'(vld[0]), 32'd1);
        chk("t1_word0",  0, ins[0], 32'h0050_0093);
        chk("t1_err0",   0, 32'(err[0]), 32'd0);
        pm_addr = 32'h4;
        tick();
        chk("t1_word1",  0, ins[0], 32'h0010_0113);
        pm_addr = 32'h2;
        tick();
        chk("misalign_err", 0, 32'(err[0]), 32'd1);
        chk("misalign_nop", 0, ins[0], 32'h0000_0013);
        pm_addr = 32'h100;
        tick();
        chk("range_err", 0, 32'(err[0]), 32'd1);
        chk("range_nop", 0, ins[0], 32'h0000_0013);

        // Error cases on base 0x1000, LATENCY=2
        pm_addr = 32'h1002; tick();
        pm_addr = 32'h1100; tick();
        chk("b_misalign_err", 2, 32'(err[2]), 32'd1);
        chk("b_misalign_nop", 2, ins[2], 32'h0000_0013);
        pm_addr = 32'h0FFC; tick();
        chk("b_range_err", 2, 32'(err[2]), 32'd1);
        pm_rd = 1'b0; tick();
        chk("b_below_err", 2, 32'(err[2]), 32'd1);
        chk("b_below_nop", 2, ins[2], 32'h0000_0013);
        pm_rd = 1'b1; pm_addr = 32'h1000; tick();
        pm_rd = 1'b0; tick();
        chk("b_unchanged", 2, ins[2], 32'h0050_0093);

        // Write and fetch in the same cycle
        pm_rd = 1'b1; pm_addr = 32'h8;
        wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        #1;
        chk("wr_blocks_ready", 0, 32'(rdy[0]), 32'd0);
        tick();
        wr_en = 1'b0; wr_be = 4'h0;
        chk("wr_no_accept", 0, 32'(vld[0]), 32'd0);
        tick();
        chk("raw_valid", 0, 32'(vld[0]), 32'd1);
        chk("raw_word",  0, ins[0], 32'hCAFE_F00D);
        pm_rd = 1'b0;

        // Byte-enable merge
        write_word(32'hC, 32'h1122_3344, 4'hF);
        write_word(32'hC, 32'hAABB_CCDD, 4'b0101);
        pm_rd = 1'b1; pm_addr = 32'hC; tick();
        pm_rd = 1'b0;
        chk("be_merge", 0, ins[0], 32'h11BB_33DD);
        tick();

        // Four back-to-back accepts on the LATENCY=3 instance
        for (int i = 0; i < 4; i++) begin
            pm_rd = 1'b1; pm_addr = 32'h1000 + 32'(4 * i);
            tick();
        end
        pm_rd = 1'b0;
        chk("l3_second", 1, ins[1], 32'h0010_0113);
        repeat (4) tick();

        // Reset on the cycle after two accepts
        pm_rd = 1'b1; pm_addr = 32'h1000; tick();
        pm_addr = 32'h1004; tick();
        pm_rd = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_drop_l2", 2, 32'(vld[2]), 32'd0);
            chk("rst_drop_l3", 1, 32'(vld[1]), 32'd0);
            tick();
        end
        pm_rd = 1'b1; pm_addr = 32'h1004; tick();
        pm_rd = 1'b0; tick();
        chk("post_rst_read", 2, ins[2], 32'h0010_0113);
        tick();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            pm_rd   = ($urandom_range(0, 3) != 0);
            pm_addr = rand_addr();
            wr_en   = !rst && ($urandom_range(0, 9) == 0);
            wr_addr = rand_addr();
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; pm_rd = 1'b0; wr_en = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
